phi2_clock_gen: RTL
===================

// Module: phi2_clock_gen
// PURPOSE
//   Generates the CPU bus clock phi2 and the phi2_cycle phase counter from clk (6 ns).
//   Sits directly upstream of bus_controller, which times address latch, bus_sync and
//   write_enable off these outputs. Also sequences the CPU reset line after system reset.
// PARAMETERS
//   PHI2_LOW_CYCLES   12'd11  clk cycles per phi2 low phase; must be >= 6 (latch @4, sync @5)
//   PHI2_HIGH_CYCLES  12'd10  clk cycles per phi2 high phase; must be >= 9 (write_enable @8)
//   CPU_RESET_PERIODS 8'd64   full phi2 periods cpu_reset_n stays low after reset release
//   STRETCH_MAX       12'd64  max extra high-phase clk cycles per stretch (PHI2_STRETCH_EN only)
// PORTS
//   clk            in   1   system clock, 6 ns period
//   reset          in   1   synchronous, active-high reset
//   phi2           out  1   CPU clock
//   phi2_cycle     out  12  clk cycles elapsed in current phi2 phase, 0 on each edge
//   phi2_rise      out  1   high for the one clk where phi2==1 && phi2_cycle==0
//   phi2_fall      out  1   high for the one clk where phi2==0 && phi2_cycle==0
//   cpu_reset_n    out  1   CPU RESB, active low
//   wait_req       in   1   hold phi2 high (PHI2_STRETCH_EN only)
//   stretch_timeout out 1   one-clk pulse when STRETCH_MAX hit (PHI2_STRETCH_EN only)
// BEHAVIOUR
//   - All outputs registered (phi2_rise/fall decoded from registered phi2/phi2_cycle).
//   - Reset: phi2=0, phi2_cycle=0, cpu_reset_n=0, period count=0, stretch_timeout=0;
//     phi2_fall therefore reads 1 during reset. Reset mid-phase aborts it; first clk
//     after release is low phase, cycle 1.
//   - States LOW, HIGH (+STRETCH with macro). LOW: cycle counts 0..LOW_CYCLES-1, then
//     phi2<=1, cycle<=0 -> HIGH. HIGH: cycle 0..HIGH_CYCLES-1, then phi2<=0, cycle<=0 -> LOW.
//   - Period = LOW_CYCLES+HIGH_CYCLES clks (default 21 = 126 ns, ~7.9 MHz).
//   - phi2_cycle width 12; never wraps in LOW/HIGH; saturates at 12'hFFF in STRETCH.
//   - cpu_reset_n: count phi2 falls after reset release; goes 1 on the clk the
//     CPU_RESET_PERIODS-th fall is registered (phi2 0, cycle 0), then stays 1 until reset.
//     Count saturates; CPU_RESET_PERIODS=0 releases on first fall.
//   - Parameter violation (LOW<6, HIGH<9, STRETCH_MAX==0) -> $error at elaboration.
// CONFIGURATION
//   PHI2_STRETCH_EN defined: at HIGH cycle HIGH_CYCLES-1 with wait_req=1 enter STRETCH:
//     phi2 stays 1, phi2_cycle keeps incrementing. Exit to LOW (phi2<=0, cycle<=0) on
//     first clk with wait_req=0, or after STRETCH_MAX extra cycles (stretch_timeout=1 for
//     that clk). wait_req ignored in LOW and before HIGH_CYCLES-1; wait_req during reset
//     ignored. cpu_reset_n low: stretching disabled.
//   Not defined: wait_req/stretch_timeout ports absent; fixed periods; no STRETCH state.
// STRUCTURE
//   Package zeus_clock_pkg: PHI2_CNT_W=12, PHI2_MIN_LOW=6, PHI2_MIN_HIGH=9,
//     BUS_LATCH_CYCLE=4, BUS_SYNC_CYCLE=5, BUS_WE_CYCLE=8, phase_e {PH_LOW,PH_HIGH,PH_STRETCH}.
//   Sub-module cpu_reset_timer: counts phi2_fall pulses, drives cpu_reset_n.
// TESTING
//   Defaults, release reset -> phi2 low 11 clks / high 10 clks, phi2_cycle 0..10 / 0..9, repeat.
//   After release -> cpu_reset_n rises exactly on 64th phi2_fall, never before; stays 1.
//   Assert reset at HIGH cycle 4 -> next clk phi2=0, cycle=0, cpu_reset_n=0; restart clean.
//   STRETCH_EN, wait_req=1 for 5 clks from HIGH cycle 9 -> high phase 15 clks, cycle reaches 14.
//   STRETCH_EN, wait_req stuck 1 -> high ends after 10+64 clks, stretch_timeout one pulse.
//   PHI2_LOW_CYCLES=5 -> elaboration $error.

Source files
------------

// File: rtl/zeus_clock_pkg.sv
// zeus_clock_pkg
//   Shared constants for the phi2 clock generator and its bus-side consumers.
//   PHI2_CNT_W       width of the phi2_cycle phase counter
//   BUS_*_CYCLE      phi2 cycle numbers the bus controller acts on
//   PHI2_MIN_LOW/HIGH  shortest phases that still contain those bus events
//   phase_e          phase state of the generator (STRETCH only used with PHI2_STRETCH_EN)
package zeus_clock_pkg;

  localparam int PHI2_CNT_W = 12;

  localparam logic [PHI2_CNT_W-1:0] BUS_LATCH_CYCLE = 12'd4;
  localparam logic [PHI2_CNT_W-1:0] BUS_SYNC_CYCLE  = 12'd5;
  localparam logic [PHI2_CNT_W-1:0] BUS_WE_CYCLE    = 12'd8;

  // A phase must run at least one cycle past the last bus event timed in it.
  localparam logic [PHI2_CNT_W-1:0] PHI2_MIN_LOW  = BUS_SYNC_CYCLE + 12'd1;
  localparam logic [PHI2_CNT_W-1:0] PHI2_MIN_HIGH = BUS_WE_CYCLE + 12'd1;

  typedef enum logic [1:0] {
    PH_LOW     = 2'd0,
    PH_HIGH    = 2'd1,
    PH_STRETCH = 2'd2
  } phase_e;

endpackage

// File: rtl/cpu_reset_timer.sv
// cpu_reset_timer
//   Holds the CPU reset line low for a number of full phi2 periods after
//   system reset is released.
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   fall_evt     in   high on the clk whose edge registers a phi2 fall
//   cpu_reset_n  out  CPU RESB, active low, registered
module cpu_reset_timer #(
  parameter logic [7:0] PERIODS = 8'd64
) (
  input  logic clk,
  input  logic reset,
  input  logic fall_evt,
  output logic cpu_reset_n
);

  logic [7:0] cnt_q, cnt_d;
  logic       rstn_q, rstn_d;

  always_comb begin
    cnt_d  = cnt_q;
    rstn_d = rstn_q;
    if (fall_evt) begin
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
      // Release on the same edge that registers the PERIODS-th fall, so the
      // comparison uses the count including this fall. PERIODS=0 releases on
      // the first fall.
      if (({1'b0, cnt_q} + 9'd1) >= {1'b0, PERIODS}) begin
        rstn_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 8'd0;
      rstn_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rstn_q <= rstn_d;
    end
  end

  assign cpu_reset_n = rstn_q;

endmodule

// File: rtl/phi2_clock_gen.sv
// phi2_clock_gen
//   Generates the CPU bus clock phi2 and its phase counter phi2_cycle from clk,
//   and sequences cpu_reset_n after system reset. The bus controller times
//   address latch, bus sync and write enable off phi2/phi2_cycle.
//   clk              in   system clock (6 ns)
//   reset            in   synchronous active-high reset
//   wait_req         in   hold phi2 high at end of high phase (PHI2_STRETCH_EN only)
//   stretch_timeout  out  one-clk pulse when a stretch hits STRETCH_MAX (PHI2_STRETCH_EN only)
//   phi2             out  CPU clock, registered
//   phi2_cycle       out  clk cycles elapsed in current phase, 0 on each phi2 edge
//   phi2_rise        out  phi2==1 && phi2_cycle==0
//   phi2_fall        out  phi2==0 && phi2_cycle==0 (also reads 1 during reset)
//   cpu_reset_n      out  CPU RESB, active low
//   Build option: define PHI2_STRETCH_EN to add the wait_req high-phase stretch.
module phi2_clock_gen
  import zeus_clock_pkg::*;
#(
  parameter logic [11:0] PHI2_LOW_CYCLES   = 12'd11,
  parameter logic [11:0] PHI2_HIGH_CYCLES  = 12'd10,
  parameter logic [7:0]  CPU_RESET_PERIODS = 8'd64,
  parameter logic [11:0] STRETCH_MAX       = 12'd64
) (
  input  logic        clk,
  input  logic        reset,
`ifdef PHI2_STRETCH_EN
  input  logic        wait_req,
  output logic        stretch_timeout,
`endif
  output logic        phi2,
  output logic [11:0] phi2_cycle,
  output logic        phi2_rise,
  output logic        phi2_fall,
  output logic        cpu_reset_n
);

  if (PHI2_LOW_CYCLES < PHI2_MIN_LOW) begin : g_bad_low
    $error("phi2_clock_gen: PHI2_LOW_CYCLES too small for bus latch/sync timing");
  end
  if (PHI2_HIGH_CYCLES < PHI2_MIN_HIGH) begin : g_bad_high
    $error("phi2_clock_gen: PHI2_HIGH_CYCLES too small for write enable timing");
  end
  if (STRETCH_MAX == 12'd0) begin : g_bad_stretch
    $error("phi2_clock_gen: STRETCH_MAX must be non-zero");
  end

  phase_e                  phase_q, phase_d;
  logic                    phi2_q, phi2_d;
  logic [PHI2_CNT_W-1:0]   cycle_q, cycle_d;
  logic                    low_end, high_end;
  logic                    fall_evt;
  logic                    rstn;

  assign low_end  = (cycle_q == PHI2_LOW_CYCLES - 12'd1);
  assign high_end = (cycle_q == PHI2_HIGH_CYCLES - 12'd1);

`ifdef PHI2_STRETCH_EN
  logic [PHI2_CNT_W-1:0]   ext_q, ext_d;
  logic                    tmo_q, tmo_d;
  logic                    stretch_ok;
  logic                    stretch_max_hit;

  // No stretching while the CPU is still held in reset.
  assign stretch_ok      = wait_req && rstn;
  assign stretch_max_hit = (ext_q == STRETCH_MAX);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_LOW;
      phi2_q  <= 1'b0;
      cycle_q <= '0;
`ifdef PHI2_STRETCH_EN
      ext_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      phase_q <= phase_d;
      phi2_q  <= phi2_d;
      cycle_q <= cycle_d;
`ifdef PHI2_STRETCH_EN
      ext_q   <= ext_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_LOW: begin
        if (low_end) phase_d = PH_HIGH;
      end
      PH_HIGH: begin
        if (high_end) begin
`ifdef PHI2_STRETCH_EN
          if (stretch_ok) phase_d = PH_STRETCH;
          else            phase_d = PH_LOW;
`else
          phase_d = PH_LOW;
`endif
        end
      end
`ifdef PHI2_STRETCH_EN
      PH_STRETCH: begin
        if (!wait_req || stretch_max_hit) phase_d = PH_LOW;
      end
`endif
      default: phase_d = PH_LOW;
    endcase
  end

  // Output / counter logic
  always_comb begin
    phi2_d = (phase_d != PH_LOW);
    if ((phase_d != phase_q) && (phase_d != PH_STRETCH)) begin
      cycle_d = '0;
    end else if (cycle_q == {PHI2_CNT_W{1'b1}}) begin
      // Only reachable in a long stretch; LOW/HIGH end well before this.
      cycle_d = cycle_q;
    end else begin
      cycle_d = cycle_q + 12'd1;
    end
`ifdef PHI2_STRETCH_EN
    ext_d = '0;
    if (phase_d == PH_STRETCH) begin
      ext_d = (phase_q == PH_HIGH) ? 12'd1 : ext_q + 12'd1;
    end
    tmo_d = (phase_q == PH_STRETCH) && wait_req && stretch_max_hit;
`endif
  end

  assign fall_evt = (phase_q != PH_LOW) && (phase_d == PH_LOW);

  cpu_reset_timer #(
    .PERIODS(CPU_RESET_PERIODS)
  ) u_cpu_reset_timer (
    .clk        (clk),
    .reset      (reset),
    .fall_evt   (fall_evt),
    .cpu_reset_n(rstn)
  );

  assign phi2        = phi2_q;
  assign phi2_cycle  = cycle_q;
  assign phi2_rise   = phi2_q && (cycle_q == '0);
  assign phi2_fall   = !phi2_q && (cycle_q == '0);
  assign cpu_reset_n = rstn;
`ifdef PHI2_STRETCH_EN
  assign stretch_timeout = tmo_q;
`endif

endmodule
